// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: controller states, round count and
// the word-level helpers used by the key-step datapath.
package aes_pkg;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_HOLD   = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    // Round constant in the top byte; zero outside rounds 1..10.
    function automatic logic [31:0] rcon(input logic [3:0] round);
        logic [7:0] b;
        case (round)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir_i=0) or inverse (dir_i=1),
// sharing a single set of four S-boxes between both directions.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [3:0]   round_i,
    input  logic         dir_i,
    output logic [127:0] key_o
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] w3_inv_s;
    logic [31:0] sb_in_s;
    logic [31:0] sb_out_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    assign {w0_s, w1_s, w2_s, w3_s} = key_i;
    assign w3_inv_s = w3_s ^ w2_s;
    // The inverse step substitutes the already-recovered previous w3.
    assign sb_in_s  = rot_word(dir_i ? w3_inv_s : w3_s);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sb_in_s[8*g +: 8]),
            .out_o (sb_out_s[8*g +: 8])
        );
    end

    // Word recurrence for the selected direction.
    always_comb begin
        n0_s = w0_s ^ sb_out_s ^ rcon(round_i);
        n1_s = 32'h0;
        n2_s = 32'h0;
        n3_s = 32'h0;
        if (dir_i) begin
            n1_s = w1_s ^ w0_s;
            n2_s = w2_s ^ w1_s;
            n3_s = w3_inv_s;
        end else begin
            n1_s = w1_s ^ n0_s;
            n2_s = w2_s ^ n1_s;
            n3_s = w3_s ^ n2_s;
        end
        key_o = {n0_s, n1_s, n2_s, n3_s};
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, computed as GF(2^8) inversion followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign out_o = affine(gf_inv(in_i));

endmodule

// File: rtl/aes_inv_key_expander.sv
// AES-128 decryption key scheduler: expands forward to the round-10 key once,
// then streams round keys 10..0 over valid/ready using the inverse step.
module aes_inv_key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         start,
    output logic         busy,
    output logic         key_cached,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] cached_q;
    logic [127:0] rk_data_q;
    logic [3:0]   rk_round_q;
    logic         rk_valid_q;
    logic         rk_last_q;
    logic         busy_q;
    logic         key_cached_q;

    logic         stream_s;
    logic         hs_s;
    logic [127:0] step_in_s;
    logic [3:0]   step_round_s;
    logic [127:0] step_out_s;

    // The single key-step unit serves the expansion and the stream.
    assign stream_s     = (state_q == ST_STREAM);
    assign hs_s         = rk_valid_q & rk_ready;
    assign step_in_s    = stream_s ? rk_data_q : work_q;
    assign step_round_s = stream_s ? rk_round_q : (cnt_q + 4'd1);

    aes_key_step u_step (
        .key_i   (step_in_s),
        .round_i (step_round_s),
        .dir_i   (stream_s),
        .key_o   (step_out_s)
    );

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            work_q       <= 128'h0;
            cached_q     <= 128'h0;
            rk_data_q    <= 128'h0;
            rk_round_q   <= 4'd0;
            rk_valid_q   <= 1'b0;
            rk_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            key_cached_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_load) begin
                        work_q  <= key_in;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    work_q <= step_out_s;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == NUM_ROUNDS - 4'd1) begin
                        cached_q     <= step_out_s;
                        busy_q       <= 1'b0;
                        key_cached_q <= 1'b1;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A reload takes priority; a simultaneous start is dropped.
                    if (key_load) begin
                        work_q       <= key_in;
                        cnt_q        <= 4'd0;
                        busy_q       <= 1'b1;
                        key_cached_q <= 1'b0;
                        state_q      <= ST_EXPAND;
                    end else if (start) begin
                        rk_data_q    <= cached_q;
                        rk_round_q   <= NUM_ROUNDS;
                        rk_valid_q   <= 1'b1;
                        rk_last_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        key_cached_q <= 1'b0;
                        state_q      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (hs_s) begin
                        if (rk_round_q == 4'd0) begin
                            rk_valid_q   <= 1'b0;
                            rk_last_q    <= 1'b0;
                            busy_q       <= 1'b0;
                            key_cached_q <= 1'b1;
                            state_q      <= ST_HOLD;
                        end else begin
                            rk_data_q  <= step_out_s;
                            rk_round_q <= rk_round_q - 4'd1;
                            rk_last_q  <= (rk_round_q == 4'd1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign key_cached = key_cached_q;
    assign rk_valid   = rk_valid_q;
    assign rk_data    = rk_data_q;
    assign rk_round   = rk_round_q;
    assign rk_last    = rk_last_q;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
// Self-checking bench: known-answer key schedules streamed through a scoreboard,
// with backpressure, replay, ignored-request and mid-stream reset sequences.
module tb_aes_inv_key_expander;

    typedef struct packed {
        logic [127:0]       key;
        logic [10:0][127:0] rks;
    } vec_t;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         start;
    logic         busy;
    logic         key_cached;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    int errors = 0;
    int checks = 0;
    vec_t tab [2];
    logic [10:0][127:0] cur_rks;
    exp_t sb_q [$];

    aes_inv_key_expander dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
        .start      (start),
        .busy       (busy),
        .key_cached (key_cached),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
        .rk_last    (rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a key and measure the cycles until key_cached rises.
    task automatic load_key(input logic [127:0] key, input bit with_start, input bit disturb);
        int  cyc;
        bit  busy_ok;
        key_in   = key;
        key_load = 1'b1;
        start    = with_start;
        tick();
        key_load = 1'b0;
        start    = 1'b0;
        chk("valid_low_after_load", 128'(rk_valid), 128'd0);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!key_cached && cyc < 30) begin
            if (!busy) busy_ok = 1'b0;
            if (disturb && cyc == 3) begin
                key_load = 1'b1;
                start    = 1'b1;
                key_in   = ~key;
            end else begin
                key_load = 1'b0;
                start    = 1'b0;
            end
            tick();
            cyc++;
        end
        key_load = 1'b0;
        start    = 1'b0;
        chk("expand_latency", 128'(cyc), 128'd10);
        chk("busy_during_expand", 128'(busy_ok), 128'd1);
        chk("busy_after_expand", 128'(busy), 128'd0);
    endtask

    // Start a stream, push the expected keys and compare every handshake.
    task automatic stream_run(input int stall_pct, input bit disturb);
        int   hs;
        int   cyc;
        int   vcyc;
        bit   r;
        bit   stalled;
        exp_t held;
        exp_t e;
        chk("busy_before_start", 128'(busy), 128'd0);
        chk("cached_before_start", 128'(key_cached), 128'd1);
        for (int k = 10; k >= 0; k--) begin
            sb_q.push_back('{data: cur_rks[k], round: 4'(k), last: (k == 0)});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("valid_after_start", 128'(rk_valid), 128'd1);
        hs      = 0;
        cyc     = 0;
        vcyc    = 0;
        stalled = 1'b0;
        held    = '0;
        while (hs < 11 && cyc < 300) begin
            if (stalled) begin
                chk("stall_valid", 128'(rk_valid), 128'd1);
                chk("stall_data", rk_data, held.data);
                chk("stall_round_last", 128'({rk_round, rk_last}), 128'({held.round, held.last}));
            end
            r = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= stall_pct);
            rk_ready = r;
            if (disturb && cyc == 3) begin
                key_load = 1'b1;
                start    = 1'b1;
                key_in   = {4{$urandom}};
            end else begin
                key_load = 1'b0;
                start    = 1'b0;
            end
            if (rk_valid) vcyc++;
            if (rk_valid && r) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_key", 128'(rk_round), 128'hffff);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("rk_data_r%0d", e.round), rk_data, e.data);
                    chk($sformatf("rk_round_r%0d", e.round), 128'(rk_round), 128'(e.round));
                    chk($sformatf("rk_last_r%0d", e.round), 128'(rk_last), 128'(e.last));
                end
                hs++;
                stalled = 1'b0;
            end else if (rk_valid) begin
                stalled = 1'b1;
                held    = '{data: rk_data, round: rk_round, last: rk_last};
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        rk_ready = 1'b0;
        key_load = 1'b0;
        start    = 1'b0;
        chk("handshake_count", 128'(hs), 128'd11);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        chk("valid_after_stream", 128'(rk_valid), 128'd0);
        chk("cached_after_stream", 128'(key_cached), 128'd1);
        chk("busy_after_stream", 128'(busy), 128'd0);
        if (stall_pct == 0) chk("valid_cycles", 128'(vcyc), 128'd11);
        sb_q.delete();
    endtask

    initial begin
        int cyc;

        tab[0].key     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tab[0].rks[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tab[0].rks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        tab[0].rks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        tab[0].rks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        tab[0].rks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        tab[0].rks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        tab[0].rks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        tab[0].rks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        tab[0].rks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        tab[0].rks[9]  = 128'hac7766f319fadc2128d12941575c006e;
        tab[0].rks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        tab[1].key     = 128'h0;
        tab[1].rks[0]  = 128'h0;
        tab[1].rks[1]  = 128'h62636363626363636263636362636363;
        tab[1].rks[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        tab[1].rks[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        tab[1].rks[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        tab[1].rks[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        tab[1].rks[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        tab[1].rks[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        tab[1].rks[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        tab[1].rks[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        tab[1].rks[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst      = 1'b1;
        key_in   = 128'h0;
        key_load = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        repeat (3) tick();
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_cached", 128'(key_cached), 128'd0);
        chk("reset_valid", 128'(rk_valid), 128'd0);
        chk("reset_data", rk_data, 128'd0);
        chk("reset_round_last", 128'({rk_round, rk_last}), 128'd0);
        rst = 1'b0;
        tick();

        // Start before any key is loaded must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_in_idle", 128'({busy, rk_valid}), 128'd0);

        for (int v = 0; v < 2; v++) begin
            cur_rks = tab[v].rks;
            load_key(tab[v].key, 1'b0, 1'b0);
            stream_run(0, 1'b0);
        end

        // Replay of the cached zero-key schedule under backpressure.
        stream_run(50, 1'b0);

        // Requests during EXPAND and STREAM are ignored; then stalled replay.
        cur_rks = tab[0].rks;
        load_key(tab[0].key, 1'b0, 1'b1);
        stream_run(0, 1'b1);
        stream_run(50, 1'b0);

        // key_load and start together in HOLD: re-expansion, no stream.
        cur_rks = tab[1].rks;
        load_key(tab[1].key, 1'b1, 1'b0);
        stream_run(0, 1'b0);

        // Reset at round 5 of a stream.
        start = 1'b1;
        tick();
        start    = 1'b0;
        rk_ready = 1'b1;
        cyc      = 0;
        while (rk_round != 4'd5 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("reached_round5", 128'(rk_round), 128'd5);
        rk_ready = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_data", rk_data, 128'd0);
        chk("abort_round_last", 128'({rk_round, rk_last}), 128'd0);
        chk("abort_busy_cached", 128'({busy, key_cached}), 128'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_after_abort", 128'({busy, rk_valid, key_cached}), 128'd0);

        // Recovery with a fresh load.
        cur_rks = tab[0].rks;
        load_key(tab[0].key, 1'b0, 1'b0);
        stream_run(30, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
